// File: rtl/cache_data_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_data_array                                             |
// | Description : N-way set-associative cache data store with word write masks,|
// |               registered reads and a whole-array clear engine.             |
// |               Optional per-word even parity: CACHE_DATA_PARITY_EN.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cache_data_array #(
    parameter int NUM_WAYS = 2,
    parameter int SETS     = 1024,
    parameter int LINE_W   = 128,
    parameter int WORD_W   = 32,
    localparam int IDX_W   = $clog2(SETS),
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int WORDS   = LINE_W / WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [WAY_W-1:0]  req_way,
    input  logic [WORDS-1:0]  req_wmask,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [LINE_W-1:0] rd_data,
    input  logic              flush,
    output logic              busy,
    output logic              flush_done,
    input  logic              par_inject,
    output logic              par_err
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SETS - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_clr_idx;
    logic [IDX_W-1:0]    w_clr_idx_nxt;
    logic                r_flush_done;
    logic                w_flush_done_nxt;
    logic                w_clr;
    logic                w_accept;
    logic                w_rd_acc;
    logic [WORDS-1:0][WORD_W-1:0] w_rd_words;

    assign busy       = (r_state == ST_INIT);
    assign req_ready  = (r_state == ST_READY) && !flush;
    assign flush_done = r_flush_done;
    assign w_clr      = (r_state == ST_INIT);
    assign w_accept   = req_valid && req_ready;
    assign w_rd_acc   = w_accept && !req_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_clr_idx    <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_idx    <= w_clr_idx_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    // flush is only honoured in READY; a clear in progress always runs to completion
    always_comb begin
        w_state_nxt      = r_state;
        w_clr_idx_nxt    = r_clr_idx;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt      = ST_READY;
                    w_clr_idx_nxt    = '0;
                    w_flush_done_nxt = 1'b1;
                end
            end
            ST_READY: begin
                if (flush) begin
                    w_state_nxt   = ST_INIT;
                    w_clr_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_INIT;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

`ifdef CACHE_DATA_PARITY_EN
    logic [WORDS-1:0] w_par_mis;
`endif

    // One storage bank per word per way so word masks map to plain write enables
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            logic [NUM_WAYS-1:0][WORD_W-1:0] w_way_rd;
`ifdef CACHE_DATA_PARITY_EN
            logic [NUM_WAYS-1:0]             w_way_par;
`endif
            for (genvar gw = 0; gw < NUM_WAYS; gw++) begin : g_way
                logic [WORD_W-1:0] r_mem [SETS];
                logic              w_wr_en;

                assign w_wr_en = w_accept && req_we && req_wmask[gi]
                                 && (req_way == WAY_W'(gw));

                always_ff @(posedge clk) begin
                    if (w_clr) begin
                        r_mem[r_clr_idx] <= '0;
                    end else if (w_wr_en) begin
                        r_mem[req_index] <= req_wdata[gi*WORD_W +: WORD_W];
                    end
                end

                assign w_way_rd[gw] = r_mem[req_index];
`ifdef CACHE_DATA_PARITY_EN
                logic r_par [SETS];

                always_ff @(posedge clk) begin
                    if (w_clr) begin
                        r_par[r_clr_idx] <= 1'b0;
                    end else if (w_wr_en) begin
                        r_par[req_index] <= (^req_wdata[gi*WORD_W +: WORD_W]) ^ par_inject;
                    end
                end

                assign w_way_par[gw] = r_par[req_index];
`endif
            end
            assign w_rd_words[gi] = w_way_rd[req_way];
`ifdef CACHE_DATA_PARITY_EN
            assign w_par_mis[gi] = (^w_way_rd[req_way]) ^ w_way_par[req_way];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                rd_data <= w_rd_words;
            end
        end
    end

`ifdef CACHE_DATA_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= w_rd_acc && (|w_par_mis);
        end
    end
`else
    logic w_unused;
    assign w_unused = par_inject;
    assign par_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_data_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cache_data_array                                          |
// | Description : Directed self-checking bench for cache_data_array.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cache_data_array;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [9:0]   req_index;
    logic [0:0]   req_way;
    logic [3:0]   req_wmask;
    logic [127:0] req_wdata;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         flush;
    logic         busy;
    logic         flush_done;
    logic         par_inject;
    logic         par_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] c_FULL  = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] c_BASE  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] c_MIXED = 128'h11111111_FFFFFFFF_33333333_FFFFFFFF;
`ifdef CACHE_DATA_PARITY_EN
    localparam logic c_INJ_PAR = 1'b1;
`else
    localparam logic c_INJ_PAR = 1'b0;
`endif

    cache_data_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_index  (req_index),
        .req_way    (req_way),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .flush      (flush),
        .busy       (busy),
        .flush_done (flush_done),
        .par_inject (par_inject),
        .par_err    (par_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic way, input logic [9:0] idx,
                            input logic [3:0] mask, input logic [127:0] data, input logic inj);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_way    = way;
        req_index  = idx;
        req_wmask  = mask;
        req_wdata  = data;
        par_inject = inj;
        #1 check({tag, "_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        par_inject = 1'b0;
        check({tag, "_no_rdvalid"}, rd_valid, 0);
    endtask

    task automatic do_read(input string tag, input logic way, input logic [9:0] idx,
                           input logic [127:0] exp, input logic exp_par);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_way   = way;
        req_index = idx;
        req_wmask = '0;
        #1 check({tag, "_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_rdvalid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_parerr"}, par_err, exp_par);
    endtask

    // Counts cycles with busy high, optionally pulsing flush mid-clear (must be ignored)
    task automatic wait_clear(input string tag, input int flush_at);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            flush = (n == flush_at);
            @(posedge clk); #1;
            n++;
        end
        flush = 1'b0;
        check({tag, "_busy_cycles"}, 128'(n), 128'd1024);
        check({tag, "_done_pulse"}, flush_done, 1);
        check({tag, "_ready_after"}, req_ready, 1);
        @(posedge clk); #1;
        check({tag, "_done_single"}, flush_done, 0);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_index  = '0;
        req_way    = '0;
        req_wmask  = '0;
        req_wdata  = '0;
        flush      = 1'b0;
        par_inject = 1'b0;

        #12;
        check("rst_busy", busy, 1);
        check("rst_ready", req_ready, 0);
        check("rst_rdvalid", rd_valid, 0);
        check("rst_rddata", rd_data, 0);
        check("rst_done", flush_done, 0);
        check("rst_parerr", par_err, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear("init", -1);

        do_read("rd_w1_1023", 1'b1, 10'd1023, '0, 1'b0);

        do_write("wr_full", 1'b0, 10'd5, 4'b1111, c_FULL, 1'b0);
        do_read("rd_full", 1'b0, 10'd5, c_FULL, 1'b0);
        do_read("rd_other_way", 1'b1, 10'd5, '0, 1'b0);

        do_write("wr_base", 1'b0, 10'd9, 4'b1111, c_BASE, 1'b0);
        do_write("wr_partial", 1'b0, 10'd9, 4'b0101, '1, 1'b0);
        do_read("rd_partial", 1'b0, 10'd9, c_MIXED, 1'b0);
        do_write("wr_nomask", 1'b0, 10'd9, 4'b0000, '0, 1'b0);
        do_read("rd_nomask", 1'b0, 10'd9, c_MIXED, 1'b0);

        // Back-to-back reads keep rd_valid high; data then holds
        req_valid = 1'b1; req_we = 1'b0; req_way = 1'b0; req_index = 10'd5;
        @(posedge clk); #1;
        req_index = 10'd9;
        check("b2b_v0", rd_valid, 1);
        check("b2b_d0", rd_data, c_FULL);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_v1", rd_valid, 1);
        check("b2b_d1", rd_data, c_MIXED);
        @(posedge clk); #1;
        check("b2b_v_idle", rd_valid, 0);
        check("b2b_hold", rd_data, c_MIXED);

        do_write("wr_inj", 1'b1, 10'd7, 4'b1111, 128'h1, 1'b1);
        do_read("rd_inj", 1'b1, 10'd7, 128'h1, c_INJ_PAR);
        do_write("wr_noinj", 1'b1, 10'd7, 4'b1111, 128'h1, 1'b0);
        do_read("rd_noinj", 1'b1, 10'd7, 128'h1, 1'b0);

        // flush and a write request in the same cycle: flush wins
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_way = 1'b0;
        req_index = 10'd9; req_wmask = 4'b1111; req_wdata = {4{32'hAAAA_AAAA}};
        #1 check("flush_blocks_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        check("flush_busy", busy, 1);
        check("flush_no_rdvalid", rd_valid, 0);
        wait_clear("flush", 100);
        do_read("rd_cleared_5", 1'b0, 10'd5, '0, 1'b0);
        do_read("rd_cleared_9", 1'b0, 10'd9, '0, 1'b0);
        do_read("rd_cleared_7", 1'b1, 10'd7, '0, 1'b0);

        // Reset with a read result outstanding
        do_write("wr_pre_rst", 1'b1, 10'd3, 4'b1111, c_FULL, 1'b0);
        do_read("rd_pre_rst", 1'b1, 10'd3, c_FULL, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrd_rdvalid", rd_valid, 0);
        check("midrd_rddata", rd_data, 0);
        check("midrd_busy", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear("midrd", -1);

        // Reset partway through a clear
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("midclr_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midclr_busy", busy, 1);
        check("midclr_rdvalid", rd_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear("midclr", -1);
        do_read("rd_after_midclr", 1'b1, 10'd3, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
